// File: rtl/spu32_wb8_defs_pkg.sv
// Shared definitions for the wb8 byte-wide Wishbone peripherals:
// responder state encoding and byte-lane helpers for 32-bit backing stores.
package spu32_wb8_defs_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } wb8_state_e;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  function automatic logic [3:0] laneMask(input logic [1:0] lane);
    laneMask = 4'b0001 << lane;
  endfunction

  // Little-endian: lane 0 is bits 7:0.
  function automatic logic [7:0] laneByte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      LANE0:   laneByte = word[7:0];
      LANE1:   laneByte = word[15:8];
      LANE2:   laneByte = word[23:16];
      default: laneByte = word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/spu32_ram32_bytewe.sv
// Synchronous 32-bit RAM with per-byte write enables and a registered read port.
module spu32_ram32_bytewe #(
  parameter int WORD_AW = 10
) (
  input  logic               clk_i,
  input  logic [3:0]         we_i,
  input  logic               re_i,
  input  logic [WORD_AW-1:0] addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem_q [2**WORD_AW];
  logic [31:0] rdata_q;

  // Read returns the pre-write contents when read and write hit the same word.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spu32_wb8_ram.sv
// Byte-wide pipelined Wishbone RAM over a 32-bit store with an optional one-word
// read line buffer, enabled by defining SPU32_WB8_RAM_LINEBUF_EN.
module spu32_wb8_ram
  import spu32_wb8_defs_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  CLK_I,
  input  logic                  reset,
  input  logic                  CYC_I,
  input  logic                  STB_I,
  input  logic                  WE_I,
  input  logic [ADDR_WIDTH-1:0] ADR_I,
  input  logic [7:0]            DAT_I,
  output logic [7:0]            DAT_O,
  output logic                  ACK_O,
  output logic                  STALL_O
);

  wb8_state_e  state_q;
  logic        ack_q;
  logic [7:0]  dat_q;
  logic [1:0]  fillLane_q;
  logic        accept;
  logic        lineHit;
  logic [7:0]  hitByte;
  logic [3:0]  ramWe;
  logic [31:0] ramRdata;

  assign STALL_O = (state_q == ST_FILL);
  assign accept  = CYC_I & STB_I & ~STALL_O;
  assign ramWe   = (accept & WE_I) ? laneMask(ADR_I[1:0]) : 4'b0000;
  assign ACK_O   = ack_q;
  assign DAT_O   = dat_q;

  spu32_ram32_bytewe #(.WORD_AW(ADDR_WIDTH-2)) u_ram (
    .clk_i   (CLK_I),
    .we_i    (ramWe),
    .re_i    (accept & ~WE_I),
    .addr_i  (ADR_I[ADDR_WIDTH-1:2]),
    .wdata_i ({4{DAT_I}}),
    .rdata_o (ramRdata)
  );

`ifdef SPU32_WB8_RAM_LINEBUF_EN
  logic [31:0]           line_q;
  logic [ADDR_WIDTH-3:0] tag_q;
  logic [ADDR_WIDTH-3:0] fillTag_q;
  logic                  valid_q;

  assign lineHit = valid_q && (tag_q == ADR_I[ADDR_WIDTH-1:2]);
  assign hitByte = laneByte(line_q, ADR_I[1:0]);

  // Writes update the buffered copy so it never goes stale against the RAM.
  always_ff @(posedge CLK_I) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (state_q == ST_FILL) begin
      line_q  <= ramRdata;
      tag_q   <= fillTag_q;
      valid_q <= 1'b1;
    end else if (accept) begin
      if (WE_I && lineHit) line_q[{ADR_I[1:0], 3'b000} +: 8] <= DAT_I;
      if (!WE_I && !lineHit) fillTag_q <= ADR_I[ADDR_WIDTH-1:2];
    end
  end
`else
  assign lineHit = 1'b0;
  assign hitByte = 8'h00;
`endif

  // A FILL always finishes even if the master abandons the cycle; only the ACK is dropped.
  always_ff @(posedge CLK_I) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      dat_q      <= 8'h00;
      fillLane_q <= LANE0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (WE_I) begin
              ack_q <= 1'b1;
            end else if (lineHit) begin
              ack_q <= 1'b1;
              dat_q <= hitByte;
            end else begin
              state_q    <= ST_FILL;
              fillLane_q <= ADR_I[1:0];
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          if (CYC_I) begin
            ack_q <= 1'b1;
            dat_q <= laneByte(ramRdata, fillLane_q);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spu32_wb8_ram.sv
// Self-checking bench for spu32_wb8_ram: directed scenarios plus randomized traffic
// against a byte-array memory model with a one-word buffered-tag predictor.
module tb_spu32_wb8_ram;

  logic        CLK_I = 1'b0;
  logic        reset = 1'b1;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic [11:0] ADR_I = '0;
  logic [7:0]  DAT_I = '0;
  logic [7:0]  DAT_O;
  logic        ACK_O;
  logic        STALL_O;

`ifdef SPU32_WB8_RAM_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: byte memory, remembered buffered word, last driven read data
  logic [7:0] mem [4096];
  bit         written [4096];
  bit         mValid = 1'b0;
  int         mTag = 0;
  logic [7:0] lastDat = 8'h00;

  spu32_wb8_ram #(.ADDR_WIDTH(12)) dut (
    .CLK_I   (CLK_I),
    .reset   (reset),
    .CYC_I   (CYC_I),
    .STB_I   (STB_I),
    .WE_I    (WE_I),
    .ADR_I   (ADR_I),
    .DAT_I   (DAT_I),
    .DAT_O   (DAT_O),
    .ACK_O   (ACK_O),
    .STALL_O (STALL_O)
  );

  always #5 CLK_I = ~CLK_I;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit predictHit(input int a);
    return LB && mValid && (mTag == (a >> 2));
  endfunction

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic busWrite(input int a, input logic [7:0] d);
    ADR_I = a[11:0]; DAT_I = d; WE_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1;
    checkOutput("wr_stall_pre", STALL_O, 1'b0);
    tick();
    STB_I = 1'b0;
    checkOutput("wr_ack", ACK_O, 1'b1);
    checkOutput("wr_nostall", STALL_O, 1'b0);
    checkOutput("wr_dat_unchanged", DAT_O, lastDat);
    mem[a] = d;
    written[a] = 1'b1;
    tick();
    checkOutput("wr_ack_pulse", ACK_O, 1'b0);
  endtask

  task automatic busRead(input int a);
    bit hit;
    logic [7:0] exp;
    hit = predictHit(a);
    exp = mem[a];
    ADR_I = a[11:0]; WE_I = 1'b0; CYC_I = 1'b1; STB_I = 1'b1;
    checkOutput("rd_stall_pre", STALL_O, 1'b0);
    tick();
    STB_I = 1'b0;
    if (!hit) begin
      checkOutput("rd_fill_stall", STALL_O, 1'b1);
      checkOutput("rd_fill_noack", ACK_O, 1'b0);
      checkOutput("rd_fill_dat_hold", DAT_O, lastDat);
      tick();
    end
    checkOutput("rd_ack", ACK_O, 1'b1);
    checkOutput("rd_data", DAT_O, exp);
    checkOutput("rd_stall_post", STALL_O, 1'b0);
    lastDat = exp;
    mValid = LB;
    mTag = a >> 2;
    tick();
    checkOutput("rd_ack_pulse", ACK_O, 1'b0);
    checkOutput("rd_dat_hold", DAT_O, lastDat);
  endtask

  task automatic applyStimulus();
    int a;
    int region;
    // Reset state
    repeat (3) tick();
    checkOutput("reset_ack", ACK_O, 1'b0);
    checkOutput("reset_stall", STALL_O, 1'b0);
    checkOutput("reset_dat", DAT_O, 8'h00);
    reset = 1'b0;
    CYC_I = 1'b1;
    tick();

    // Byte writes then a miss fill
    busWrite(32'h100, 8'h11);
    busWrite(32'h101, 8'h22);
    busWrite(32'h102, 8'h33);
    busWrite(32'h103, 8'h44);
    busRead(32'h100);

    // Remaining bytes of the word: pipelined when buffered, one stall each otherwise
    if (LB) begin
      ADR_I = 12'h101; WE_I = 1'b0; STB_I = 1'b1;
      for (int i = 1; i < 4; i++) begin
        checkOutput("b2b_nostall", STALL_O, 1'b0);
        tick();
        checkOutput("b2b_ack", ACK_O, 1'b1);
        checkOutput("b2b_data", DAT_O, mem[32'h100 + i]);
        lastDat = mem[32'h100 + i];
        ADR_I = ADR_I + 12'h1;
      end
      STB_I = 1'b0;
      tick();
      checkOutput("b2b_ack_end", ACK_O, 1'b0);
    end else begin
      for (int i = 1; i < 4; i++) busRead(32'h100 + i);
    end

    // Write into the buffered word, then read it back
    busWrite(32'h102, 8'hAB);
    busRead(32'h102);

    // Abandoned fill still loads the buffer
    busWrite(32'h200, 8'h5A);
    ADR_I = 12'h200; WE_I = 1'b0; CYC_I = 1'b1; STB_I = 1'b1;
    tick();
    STB_I = 1'b0; CYC_I = 1'b0;
    checkOutput("abort_stall", STALL_O, 1'b1);
    tick();
    checkOutput("abort_noack", ACK_O, 1'b0);
    checkOutput("abort_stall_clear", STALL_O, 1'b0);
    checkOutput("abort_dat_hold", DAT_O, lastDat);
    mValid = LB; mTag = 32'h200 >> 2;
    tick();
    checkOutput("abort_noack_late", ACK_O, 1'b0);
    CYC_I = 1'b1;
    busRead(32'h200);

    // Randomized traffic over a small window so buffered hits occur
    for (int n = 0; n < 60; n++) begin
      region = $urandom_range(0, 1) * 32'h40;
      a = 32'h400 + region + $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0 || !written[a]) busWrite(a, 8'($urandom));
      else busRead(a);
    end

    // Reset during a fill
    busWrite(32'h300, 8'h77);
    ADR_I = 12'h300; WE_I = 1'b0; CYC_I = 1'b1; STB_I = 1'b1;
    if (predictHit(32'h300)) mValid = 1'b0;
    tick();
    STB_I = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("rst_fill_noack", ACK_O, 1'b0);
    checkOutput("rst_fill_stall", STALL_O, 1'b0);
    checkOutput("rst_fill_dat", DAT_O, 8'h00);
    reset = 1'b0;
    mValid = 1'b0;
    lastDat = 8'h00;
    tick();
    checkOutput("rst_after_noack", ACK_O, 1'b0);
    busRead(32'h100);
  endtask

  initial begin
    foreach (written[i]) written[i] = 1'b0;
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spu32_wb8_ram.md
SPU32_WB8_RAM -- requirements
Module: spu32_wb8_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, byte-address width; capacity 2^ADDR_WIDTH bytes as 2^(ADDR_WIDTH-2) 32-bit words.
REQ-002 SHALL have port CLK_I  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port CYC_I  in  1  bus cycle active.
REQ-005 SHALL have port STB_I  in  1  request strobe.
REQ-006 SHALL have port WE_I  in  1  1 = write, 0 = read.
REQ-007 SHALL have port ADR_I  in  ADDR_WIDTH  byte address.
REQ-008 SHALL have port DAT_I  in  8  write data.
REQ-009 SHALL have port DAT_O  out  8  read data, valid while ACK_O high.
REQ-010 SHALL have port ACK_O  out  1  one-cycle completion pulse per accepted request.
REQ-011 SHALL have port STALL_O  out  1  request not accepted this cycle.

Function
REQ-012 SHALL accept a request on a rising edge where CYC_I & STB_I & !STALL_O; pipelined Wishbone B4 responder; ACKs in acceptance order.
REQ-013 SHALL hold one 32-bit line buffer with word tag ADR_I[ADDR_WIDTH-1:2] and valid bit.
REQ-014 SHALL implement states IDLE and FILL; STALL_O = (state == FILL), combinational from state only.
REQ-015 Read hit (IDLE, valid, tag match): ACK_O high in the cycle after the accept edge, DAT_O = buffer byte ADR_I[1:0] (lane 0 = bits 7:0, little-endian); state stays IDLE; back-to-back hits sustain one byte per cycle.
REQ-016 Read miss: accept edge issues RAM word read, state -> FILL (one stall cycle); next edge loads buffer, sets tag/valid, state -> IDLE, ACK_O high the following cycle; total 2 edges request-to-ACK.
REQ-017 Write: byte written to RAM lane ADR_I[1:0] on accept edge; if tag matches and valid, same buffer byte updated on same edge; ACK_O next cycle, no stall, DAT_O unchanged.
REQ-018 ACK_O SHALL be suppressed if CYC_I is low on the edge that would produce it; an aborted FILL still completes the buffer load.
REQ-019 Requests with CYC_I low SHALL be ignored; STB_I during FILL is not accepted and must be held by master.
REQ-020 DAT_O SHALL hold last driven value when ACK_O low.

Reset
REQ-021 reset SHALL force state IDLE, buffer valid 0, ACK_O 0, STALL_O 0, DAT_O 8'h00 on the next edge, overriding any in-flight request (no ACK issued).
REQ-022 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-023 Macro SPU32_WB8_RAM_LINEBUF_EN defined: buffer behaviour per REQ-015..017.
REQ-024 Macro undefined: valid bit tied 0; every read takes miss path (REQ-016 timing); writes per REQ-017 without buffer update.

Structure
REQ-025 State encodings (IDLE, FILL) and lane-select constants SHALL live in shared include spu32_wb8_defs, reusable by other wb8 peripherals.
REQ-026 Storage SHALL be sub-module spu32_ram32_bytewe: synchronous 32-bit RAM, 4 byte-write enables, 1-cycle registered read.

Verification
REQ-027 Write 0x11,0x22,0x33,0x44 to 0x100..0x103, read 0x100 -> STALL_O 1 one cycle, ACK 2 edges later, DAT_O 0x11.
REQ-028 Then read 0x101,0x102,0x103 back-to-back -> no stall, ACK on 3 consecutive cycles, DAT_O 0x22,0x33,0x44 (with LINEBUF_EN); without macro each stalls once.
REQ-029 After buffering 0x100, write 0xAB to 0x102, read 0x102 -> hit, DAT_O 0xAB.
REQ-030 Read miss 0x200 (RAM 0x5A), drop CYC_I during FILL -> no ACK; next read 0x200 with CYC_I -> hit, 0x5A, 1-edge latency.
REQ-031 Assert reset during FILL -> ACK_O stays 0, STALL_O 0 after edge, next read 0x100 is miss yet returns 0x11 (RAM retained).
